// File: rtl/wb_trace_fifo.sv
// Write-back trace capture FIFO: tags retiring register writes with a sequence number and drops on full.
// Optional build macro TRACE_SKIP_R0_EN excludes writes to r0 from capture entirely.
module wb_trace_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              debug_wb_pc,
  input  logic [3:0]               debug_wb_rf_we,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [31:0]              debug_wb_rf_wdata,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [3:0]               out_we,
  output logic [4:0]               out_wnum,
  output logic [31:0]              out_wdata,
  output logic [15:0]              out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 89;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [RW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;
  logic [15:0]   r_seq;

  logic          w_cap;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_flush;
  logic [RW-1:0] w_head;

`ifdef TRACE_SKIP_R0_EN
  assign w_cap = (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
`else
  assign w_cap = (debug_wb_rf_we != 4'd0);
`endif

  assign w_flush = reset || clear;
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = out_valid && out_ready;
  // A pop frees the slot in the same edge, so a full FIFO can still accept a record.
  assign w_push  = w_cap && (!w_full || w_pop);
  assign w_drop  = w_cap && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      r_seq      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_cap) r_seq <= r_seq + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!w_flush && w_push)
      r_mem[r_wr_ptr] <= {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, r_seq};
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? w_head[88:57] : 32'd0;
  assign out_we    = out_valid ? w_head[56:53] : 4'd0;
  assign out_wnum  = out_valid ? w_head[52:48] : 5'd0;
  assign out_wdata = out_valid ? w_head[47:16] : 32'd0;
  assign out_seq   = out_valid ? w_head[15:0]  : 16'd0;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed test-plan scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_wb_trace_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, clear, out_ready;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic        out_valid, overflow;
  logic [31:0] out_pc, out_wdata;
  logic [3:0]  out_we;
  logic [4:0]  out_wnum;
  logic [15:0] out_seq, drop_cnt;
  logic [3:0]  count;

  wb_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_we(out_we), .out_wnum(out_wnum), .out_wdata(out_wdata),
    .out_seq(out_seq), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic [15:0] seq;
  } rec_t;

  rec_t        m_q[$];
  logic [15:0] m_seq = 16'd0;
  int          m_drops = 0;
  logic        m_ovf = 1'b0;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue, a counter, and the drop rules.
  always @(posedge clk) begin
    bit cap, pop, full;
    rec_t r;
    if (reset || clear) begin
      m_q.delete();
      m_seq = 16'd0;
      m_drops = 0;
      m_ovf = 1'b0;
    end else begin
`ifdef TRACE_SKIP_R0_EN
      cap = (debug_wb_rf_we != 0) && (debug_wb_rf_wnum != 0);
`else
      cap = (debug_wb_rf_we != 0);
`endif
      full = (m_q.size() == DEPTH);
      pop = (m_q.size() != 0) && out_ready;
      if (pop) void'(m_q.pop_front());
      if (cap) begin
        if (!full || pop) begin
          r = '{debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, m_seq};
          m_q.push_back(r);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 16'hFFFF) m_drops++;
        end
        m_seq = m_seq + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    rec_t h;
    if (chk_en) begin
      h = (m_q.size() != 0) ? m_q[0] : '0;
      chk("m_valid", 64'(out_valid), 64'(m_q.size() != 0));
      chk("m_count", 64'(count), 64'(m_q.size()));
      chk("m_pc", 64'(out_pc), 64'(h.pc));
      chk("m_we", 64'(out_we), 64'(h.we));
      chk("m_wnum", 64'(out_wnum), 64'(h.wnum));
      chk("m_wdata", 64'(out_wdata), 64'(h.wdata));
      chk("m_seq", 64'(out_seq), 64'(h.seq));
      chk("m_overflow", 64'(overflow), 64'(m_ovf));
      chk("m_drop_cnt", 64'(drop_cnt), 64'(m_drops));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cap_on(input logic [4:0] wn);
    debug_wb_pc = $urandom;
    debug_wb_rf_wdata = $urandom;
    debug_wb_rf_we = 4'(($urandom_range(0, 14)) + 1);
    debug_wb_rf_wnum = wn;
  endtask

  task automatic idle();
    debug_wb_rf_we = 4'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
  endtask

  // Five records held and two drops, then flush by clear (which=0) or reset (which=1) with a capture.
  task automatic flush_case(input int which);
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin cap_on(5'd3); cyc(); end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    out_ready = 1'b0;
    chk("pre_count", 64'(count), 64'd5);
    chk("pre_drop", 64'(drop_cnt), 64'd2);
    cap_on(5'd7);
    if (which == 0) clear = 1'b1; else reset = 1'b1;
    cyc();
    clear = 1'b0;
    reset = 1'b0;
    idle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);
    chk("flush_drop", 64'(drop_cnt), 64'd0);
    cap_on(5'd9);
    cyc();
    idle();
    chk("flush_seq", 64'(out_seq), 64'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; out_ready = 1'b0;
    debug_wb_pc = '0; debug_wb_rf_wdata = '0; debug_wb_rf_we = '0; debug_wb_rf_wnum = '0;
    cyc(); cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);

    // Basic
    debug_wb_pc = 32'h1c000000; debug_wb_rf_we = 4'hF;
    debug_wb_rf_wnum = 5'd4; debug_wb_rf_wdata = 32'h12345678;
    cyc();
    idle();
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_seq", 64'(out_seq), 64'd0);
    chk("basic_count", 64'(count), 64'd1);
    chk("basic_pc", 64'(out_pc), 64'h1c000000);
    chk("basic_we", 64'(out_we), 64'hF);
    chk("basic_wnum", 64'(out_wnum), 64'd4);
    chk("basic_wdata", 64'(out_wdata), 64'h12345678);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("basic_drain_count", 64'(count), 64'd0);
    chk("basic_drain_pc", 64'(out_pc), 64'd0);
    chk("basic_drain_wdata", 64'(out_wdata), 64'd0);

    // Streaming
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cap_on(5'(i + 1));
      cyc();
      chk("stream_seq", 64'(out_seq), 64'(i));
      chk("stream_count", 64'(count), 64'd1);
    end
    idle();
    cyc();
    chk("stream_end_count", 64'(count), 64'd0);
    chk("stream_ovf", 64'(overflow), 64'd0);

    // Overflow
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin cap_on(5'd2); cyc(); end
    idle();
    chk("ovf_count", 64'(count), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_seq", 64'(out_seq), 64'(i));
      cyc();
    end
    out_ready = 1'b0;
    chk("ovf_empty", 64'(count), 64'd0);
    cap_on(5'd6);
    cyc();
    idle();
    chk("ovf_next_seq", 64'(out_seq), 64'd11);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Full with pop
    for (int i = 0; i < 8; i++) begin cap_on(5'd8); cyc(); end
    idle();
    chk("fp_full", 64'(count), 64'd8);
    cap_on(5'd8);
    out_ready = 1'b1;
    cyc();
    idle();
    chk("fp_count", 64'(count), 64'd8);
    chk("fp_drop", 64'(drop_cnt), 64'd3);
    for (int i = 0; i < 8; i++) begin
      chk("fp_drain_seq", 64'(out_seq), 64'(13 + i));
      cyc();
    end
    out_ready = 1'b0;

    flush_case(0);
    flush_case(1);

    // r0 handling
    do_reset();
    out_ready = 1'b0;
    cap_on(5'd0);
    cyc();
    idle();
`ifdef TRACE_SKIP_R0_EN
    chk("r0_count", 64'(count), 64'd0);
    cap_on(5'd5);
    cyc();
    idle();
    chk("r0_next_seq", 64'(out_seq), 64'd0);
`else
    chk("r0_count", 64'(count), 64'd1);
    chk("r0_wnum", 64'(out_wnum), 64'd0);
    chk("r0_seq", 64'(out_seq), 64'd0);
`endif

    // Randomized traffic, with phases biased toward filling and toward draining
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int bias;
      bias = (i / 250) % 3;
      if ($urandom_range(0, 99) < 70) cap_on(5'($urandom_range(0, 31)));
      else idle();
      case (bias)
        0: out_ready = ($urandom_range(0, 99) < 15);
        1: out_ready = ($urandom_range(0, 99) < 85);
        default: out_ready = ($urandom_range(0, 99) < 50);
      endcase
      clear = ($urandom_range(0, 299) == 0);
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    clear = 1'b0;
    reset = 1'b0;
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Trace capture buffer downstream of the CPU top's write-back debug port. Samples every retiring register-file write presented on `debug_wb_*`, tags it with a sequence number, and queues it in a FIFO. A trace comparator or host drains the FIFO through a valid/ready port. The CPU cannot be stalled, so a full buffer drops new records and counts every drop.

## Interface
- `DEPTH`, default 8: number of FIFO entries; must be a power of two, minimum 2.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `debug_wb_pc` input 32: PC of the retiring instruction.
- `debug_wb_rf_we` input 4: byte write enables of the retiring instruction.
- `debug_wb_rf_wnum` input 5: destination register number.
- `debug_wb_rf_wdata` input 32: write data.
- `clear` input 1: synchronous flush of the FIFO and all status.
- `out_valid` output 1: head entry available.
- `out_ready` input 1: consumer accepts the head entry.
- `out_pc` output 32: head entry PC.
- `out_we` output 4: head entry byte enables.
- `out_wnum` output 5: head entry register number.
- `out_wdata` output 32: head entry data.
- `out_seq` output 16: head entry sequence number.
- `count` output log2(DEPTH)+1: current occupancy.
- `overflow` output 1: sticky flag; at least one record dropped.
- `drop_cnt` output 16: number of dropped records, saturating.

## Operation
- Capture condition: `cap = (debug_wb_rf_we != 0)`.
- Push: a capture with a free slot writes {pc, we, wnum, wdata, seq_ctr} at `wr_ptr`. Then `wr_ptr` increments, wrapping modulo `DEPTH`.
- `seq_ctr` is 16 bits. It increments on every captured record, including dropped ones, and wraps from 0xFFFF to 0. Gaps in `out_seq` therefore expose the drops.
- Pop: `out_valid && out_ready`. `rd_ptr` increments, wrapping modulo `DEPTH`.
- `out_valid = (count != 0)`. The head fields are read combinationally at `rd_ptr` and forced to 0 when `out_valid` is 0.
- Full with `cap` and a pop in the same cycle: both happen, and `count` stays at `DEPTH`.
- Full with `cap` and no pop: the record is dropped and the FIFO is unchanged. `overflow` is set to 1. `drop_cnt` increments and saturates at 0xFFFF.
- Empty with `cap`: push only. There is no fall-through; a pop is impossible because `out_valid` is 0.
- `clear` has priority over push and pop in the same cycle. It sets both pointers, `count`, `overflow`, `drop_cnt` and `seq_ctr` to 0, and discards any capture in that cycle.
- `reset` behaves like `clear`. The storage array itself is not reset.

## Timing
- Reset values: `out_valid`=0, all `out_*` data fields=0, `count`=0, `overflow`=0, `drop_cnt`=0, internal `seq_ctr`=0.
- Latency: a capture in cycle N is visible on the `out_*` outputs in cycle N+1.
- Sustained throughput is one record per cycle when `out_ready` is held high.
- `out_*` fields stay stable while `out_valid && !out_ready`.
- `count`, `overflow` and `drop_cnt` are registered and reflect the edge just taken.
- Reset asserted mid-stream: all buffered records are lost, and the first capture after reset carries seq 0.

## Configuration
- `TRACE_SKIP_R0_EN`
  - Defined: the capture condition becomes `(debug_wb_rf_we != 0) && (debug_wb_rf_wnum != 0)`. Writes to r0 are neither stored, dropped, counted nor numbered.
  - Undefined: r0 writes are captured like any other write.

## Test plan
- **Basic.** After reset, capture pc=0x1c000000, we=0xF, wnum=4, wdata=0x12345678 with `out_ready`=0.
  - Next cycle: `out_valid`=1, `out_seq`=0, `count`=1, and the fields match the capture.
  - Raise `out_ready`: `count`=0 and the data outputs return to 0.
- **Streaming.** Capture every cycle for 20 cycles with `out_ready`=1 (`DEPTH`=8).
  - Outputs `out_seq` 0..19 in order, each one cycle after capture.
  - `count` never exceeds 1; `overflow`=0.
- **Overflow.** Capture 11 records with `out_ready`=0.
  - `count`=8, `overflow`=1, `drop_cnt`=3.
  - Drain: `out_seq` 0..7.
  - Next capture carries seq 11.
- **Full with pop.** From full, capture while popping.
  - `count` stays 8 and `drop_cnt` is unchanged.
  - The new tail entry's seq equals the last stored seq plus one.
- **Clear and reset precedence.** Assert `clear` (and, separately, `reset`) in the same cycle as a capture, with the FIFO holding 5 records and `drop_cnt`=2.
  - Next cycle: `count`=0, `overflow`=0, `drop_cnt`=0.
  - The next capture carries seq 0.
- **r0 handling.** Capture a write with wnum=0.
  - With `TRACE_SKIP_R0_EN` defined: `count` stays 0 and the next captured record has seq 0.
  - Without it: the record appears with wnum=0 and seq=0.
